muller_c_pipeline: RTL

Parametrised, clocked emulation of a four-phase Muller C-element micropipeline: DEPTH C-element control stages, each gating a WIDTH-bit data register, with request/acknowledge handshakes at both ends. It generalises the single C-element project to a full token-carrying pipeline. It also adds an enable/freeze control, a live occupancy count and a sticky protocol-violation flag. It sits under the user project wrapper, with its handshake pins driven from `io_in` and reported on `io_out`.

---
 rtl/muller_c_pipeline_pkg.sv | 26 ++
 rtl/muller_c_cell.sv | 36 +++
 rtl/muller_c_pipeline.sv | 136 +++++++++++++
 3 files changed

// File: rtl/muller_c_pipeline_pkg.sv
// Shared definitions for the clocked Muller C-element micropipeline:
// default geometry, handshake phase encoding and the C-element rule.
package muller_c_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    PH_IDLE   = 1'b0,
    PH_ACTIVE = 1'b1
  } phase_e;

  // C-element with one inverted input: rises when a=1 and bN=0, falls when
  // a=0 and bN=1, otherwise keeps its current value.
  function automatic logic cElementNext(input logic a, input logic bN, input logic cur);
    logic result;
    result = cur;
    if (a && !bN) begin
      result = PH_ACTIVE;
    end else if (!a && bN) begin
      result = PH_IDLE;
    end
    return result;
  endfunction

endpackage

// File: rtl/muller_c_cell.sv
// One synchronous C-element control stage. The second input is the
// acknowledge from the following stage, used in inverted sense.
module muller_c_cell
  import muller_c_pipeline_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic a_i,
  input  logic b_n_i,
  output logic c_o
);

  logic cState_q;
  logic cState_d;

  // Evaluate the C rule only while enabled, otherwise hold the phase.
  always_comb begin
    cState_d = cState_q;
    if (enable_i) begin
      cState_d = cElementNext(a_i, b_n_i, cState_q);
    end
  end

  // Phase register, cleared to the idle phase by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cState_q <= PH_IDLE;
    end else begin
      cState_q <= cState_d;
    end
  end

  assign c_o = cState_q;

endmodule

// File: rtl/muller_c_pipeline.sv
// Clocked four-phase micropipeline: a chain of C-element stages, each
// gating a data register, with occupancy tracking and a sticky check for
// requests withdrawn before they were acknowledged.
module muller_c_pipeline
  import muller_c_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         enable,
  input  logic                         in_req,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ack,
  output logic                         out_req,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ack,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         proto_err
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] stageC;
  logic [DEPTH-1:0] stageA;
  logic [DEPTH-1:0] stageK;
  logic [DEPTH-1:0] stageCNext;
  logic [DEPTH-1:0] stageKNext;
  logic [DEPTH-1:0] stageFire;
  logic [DEPTH-1:0] pending;

  logic [WIDTH-1:0] stageData_q [DEPTH];
  logic [WIDTH-1:0] stageData_d [DEPTH];

  logic [OCC_W-1:0] occupancy_q;
  logic [OCC_W-1:0] occupancy_d;
  logic             protoErr_q;
  logic             protoErr_d;
  logic             prevInReq_q;
  logic             protoViolation;

  // Each stage listens to its predecessor's phase and is acknowledged by
  // its successor's phase; the ends connect to the external handshakes.
  always_comb begin
    stageA = {stageC[DEPTH-2:0], in_req};
    stageK = {out_ack, stageC[DEPTH-1:1]};
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    muller_c_cell uCell (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .enable_i (enable),
      .a_i      (stageA[i]),
      .b_n_i    (stageK[i]),
      .c_o      (stageC[i])
    );
  end

  // Predict each stage's next phase so data capture and occupancy can be
  // updated on the same edge as the C-elements themselves.
  always_comb begin
    stageCNext = stageC;
    stageFire  = '0;
    if (enable) begin
      for (int i = 0; i < DEPTH; i++) begin
        stageCNext[i] = cElementNext(stageA[i], stageK[i], stageC[i]);
        stageFire[i]  = stageCNext[i] != stageC[i];
      end
    end
  end

  // A stage whose phase moves latches the data that travelled with the
  // event: the input bus for stage 0, the predecessor's register otherwise.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stageData_d[i] = stageData_q[i];
    end
    if (stageFire[0]) begin
      stageData_d[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (stageFire[i]) begin
        stageData_d[i] = stageData_q[i-1];
      end
    end
  end

  // Count stages whose event has not yet been acknowledged by their
  // consumer, looking at the phases that will exist after this edge.
  always_comb begin
    stageKNext  = {out_ack, stageCNext[DEPTH-1:1]};
    pending     = stageCNext ^ stageKNext;
    occupancy_d = occupancy_q;
    if (enable) begin
      occupancy_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        occupancy_d = occupancy_d + OCC_W'(pending[i]);
      end
    end
  end

  // Flag a request that moves again while its previous event is still
  // unacknowledged; this watches the pins even while the pipeline is frozen.
  always_comb begin
    protoViolation = (in_req != prevInReq_q) && (stageC[0] != prevInReq_q);
    protoErr_d     = protoErr_q | protoViolation;
  end

  // Data, occupancy and protocol-check state; reset discards every token.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stageData_q[i] <= '0;
      end
      occupancy_q <= '0;
      protoErr_q  <= 1'b0;
      prevInReq_q <= PH_IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stageData_q[i] <= stageData_d[i];
      end
      occupancy_q <= occupancy_d;
      protoErr_q  <= protoErr_d;
      prevInReq_q <= in_req;
    end
  end

  assign in_ack    = stageC[0];
  assign out_req   = stageC[DEPTH-1];
  assign out_data  = stageData_q[DEPTH-1];
  assign occupancy = occupancy_q;
  assign proto_err = protoErr_q;

endmodule
